// File: rtl/c17_bist_ctrl_pkg.sv
// Shared types and constants for the c17 BIST controller and its MISR.
// Also holds the LFSR step and seed-sanitising helpers.
package c17_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam int LFSR_W = 5;
    localparam int MISR_W = 16;
    localparam int IDX_W  = 10;
    localparam int HOLD_W = 8;

    localparam logic [LFSR_W-1:0] LFSR_TAP  = 5'b10100;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

    // An all-zero seed would lock the LFSR, so it is forced to 1.
    function automatic logic [LFSR_W-1:0] seed_fix(
        input logic [LFSR_W-1:0] s
    );
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] l
    );
        return {l[LFSR_W-2:0], ^(l & LFSR_TAP)};
    endfunction

endpackage

// File: rtl/c17_bist_ctrl_if.sv
// Control/response bundle between a bench and the c17 BIST controller.
// The controller sits on the slave side.
interface c17_bist_ctrl_if;
    import c17_bist_pkg::*;

    logic              start;
    logic              abort;
    logic [1:0]        resp_i;
    logic [LFSR_W-1:0] stim_o;
    logic              busy;
    logic              done;
    logic [MISR_W-1:0] signature;
    logic [IDX_W-1:0]  pattern_idx;

    modport master (
        output start,
        output abort,
        output resp_i,
        input  stim_o,
        input  busy,
        input  done,
        input  signature,
        input  pattern_idx
    );

    modport slave (
        input  start,
        input  abort,
        input  resp_i,
        output stim_o,
        output busy,
        output done,
        output signature,
        output pattern_idx
    );

endinterface

// File: rtl/c17_misr.sv
// 16-bit MISR compacting a 2-bit response per enabled cycle.
// Clear takes priority over enable.
module c17_misr
    import c17_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [1:0]        i_data,
    output logic [MISR_W-1:0] o_sig
);

    logic [MISR_W-1:0] r_sig;
    logic [MISR_W-1:0] w_fb;
    logic [MISR_W-1:0] w_next;

    always_comb begin
        w_fb   = r_sig[MISR_W-1] ? MISR_POLY : '0;
        w_next = {r_sig[MISR_W-2:0], 1'b0}
               ^ w_fb
               ^ {{(MISR_W-2){1'b0}}, i_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_clear) begin
            r_sig <= '0;
        end else if (i_enable) begin
            r_sig <= w_next;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for c17: LFSR stimulus, programmable settle, MISR capture.
// Each pattern takes HOLD_CYCLES+2 cycles (apply, settle, capture).
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int                PATTERN_COUNT = 32,
    parameter int                HOLD_CYCLES   = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 5'h1F
) (
    input  logic           clk,
    input  logic           rst_n,
    c17_bist_ctrl_if.slave bus
);

    localparam logic [LFSR_W-1:0] SEED      = seed_fix(LFSR_SEED);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PATTERN_COUNT - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] r_stim;
    logic [IDX_W-1:0]  r_idx;
    logic [HOLD_W-1:0] r_hold;
    logic              w_start_ok;
    logic              w_last_hold;
    logic              w_last_idx;
    logic              w_capture;
    logic              w_busy;
    logic              w_done;
    logic [MISR_W-1:0] w_sig;

    // Abort beats start; start only counts from IDLE or DONE.
    always_comb begin
        w_start_ok  = bus.start && !bus.abort
                   && (r_state == S_IDLE || r_state == S_DONE);
        w_last_hold = (r_hold == LAST_HOLD);
        w_last_idx  = (r_idx == LAST_IDX);
        w_capture   = (r_state == S_CAPTURE) && !bus.abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.abort) begin
            w_next_state = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) w_next_state = S_APPLY;
                end
                S_APPLY: w_next_state = S_SETTLE;
                S_SETTLE: begin
                    if (w_last_hold) w_next_state = S_CAPTURE;
                end
                S_CAPTURE: begin
                    w_next_state = w_last_idx ? S_DONE : S_APPLY;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_APPLY, S_SETTLE, S_CAPTURE: w_busy = 1'b1;
            S_DONE:                       w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
            r_stim <= '0;
            r_idx  <= '0;
            r_hold <= '0;
        end else if (bus.abort) begin
            r_stim <= '0;
        end else if (w_start_ok) begin
            r_lfsr <= SEED;
            r_idx  <= '0;
        end else begin
            unique case (r_state)
                S_APPLY: begin
                    r_stim <= r_lfsr;
                    r_hold <= '0;
                end
                S_SETTLE: r_hold <= r_hold + 1'b1;
                S_CAPTURE: begin
                    if (!w_last_idx) begin
                        r_idx  <= r_idx + 1'b1;
                        r_lfsr <= lfsr_next(r_lfsr);
                    end
                end
                default: ;
            endcase
        end
    end

    c17_misr u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_start_ok),
        .i_enable (w_capture),
        .i_data   (bus.resp_i),
        .o_sig    (w_sig)
    );

    assign bus.stim_o      = r_stim;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.signature   = w_sig;
    assign bus.pattern_idx = r_idx;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench for c17_bist_ctrl across four parameter sets.
// Expected values are hand-derived from the LFSR/MISR equations.
module tb_c17_bist_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    int   n;
    int   bc;

    c17_bist_ctrl_if b0 ();
    c17_bist_ctrl_if b1 ();
    c17_bist_ctrl_if b2 ();
    c17_bist_ctrl_if b3 ();

    c17_bist_ctrl u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    c17_bist_ctrl #(
        .PATTERN_COUNT (3),
        .HOLD_CYCLES   (4),
        .LFSR_SEED     (5'h1F)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    c17_bist_ctrl #(
        .PATTERN_COUNT (2),
        .HOLD_CYCLES   (4),
        .LFSR_SEED     (5'h1F)
    ) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    c17_bist_ctrl #(
        .PATTERN_COUNT (32),
        .HOLD_CYCLES   (2),
        .LFSR_SEED     (5'h00)
    ) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        b0.start = 0; b0.abort = 0; b0.resp_i = 2'b01;
        b1.start = 0; b1.abort = 0; b1.resp_i = 2'b10;
        b2.start = 0; b2.abort = 0; b2.resp_i = 2'b01;
        b3.start = 0; b3.abort = 0; b3.resp_i = 2'b00;
        #12;
        rst_n = 1'b1;
        tick();

        chk("rst_stim", 32'(b0.stim_o), 32'h0);
        chk("rst_busy", 32'(b0.busy), 32'h0);
        chk("rst_done", 32'(b0.done), 32'h0);
        chk("rst_sig", 32'(b0.signature), 32'h0);
        chk("rst_idx", 32'(b0.pattern_idx), 32'h0);

        // Pattern sequence, PATTERN_COUNT=3
        b1.start = 1;
        tick();
        b1.start = 0;
        tick();
        chk("seq_stim0", 32'(b1.stim_o), 32'h1F);
        chk("seq_idx0", 32'(b1.pattern_idx), 32'h0);
        chk("seq_busy", 32'(b1.busy), 32'h1);
        repeat (6) tick();
        chk("seq_stim1", 32'(b1.stim_o), 32'h1E);
        chk("seq_idx1", 32'(b1.pattern_idx), 32'h1);
        repeat (6) tick();
        chk("seq_stim2", 32'(b1.stim_o), 32'h1C);
        chk("seq_idx2", 32'(b1.pattern_idx), 32'h2);
        repeat (5) tick();
        chk("seq_done", 32'(b1.done), 32'h1);
        chk("seq_sig", 32'(b1.signature), 32'h000E);

        // Restart from DONE, then abort in SETTLE of pattern 1
        b1.start = 1;
        tick();
        b1.start = 0;
        chk("rs_done", 32'(b1.done), 32'h0);
        chk("rs_busy", 32'(b1.busy), 32'h1);
        chk("rs_sig", 32'(b1.signature), 32'h0);
        repeat (8) tick();
        chk("ab_pre_stim", 32'(b1.stim_o), 32'h1E);
        b1.abort = 1;
        tick();
        b1.abort = 0;
        chk("ab_busy", 32'(b1.busy), 32'h0);
        chk("ab_done", 32'(b1.done), 32'h0);
        chk("ab_stim", 32'(b1.stim_o), 32'h0);
        chk("ab_sig", 32'(b1.signature), 32'h0002);
        chk("ab_idx", 32'(b1.pattern_idx), 32'h1);
        tick();
        chk("ab_idle", 32'(b1.busy), 32'h0);

        // Latency and busy width, stray start at edge 5
        b2.start = 1;
        tick();
        b2.start = 0;
        bc = b2.busy ? 1 : 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (n == 4) b2.start = 1;
            if (n == 5) b2.start = 0;
            if (b2.done) break;
            if (b2.busy) bc++;
        end
        chk("lat_edges", 32'(n), 32'd12);
        chk("lat_busy", 32'(bc), 32'd12);
        chk("lat_done", 32'(b2.done), 32'h1);
        chk("sig01", 32'(b2.signature), 32'h0003);
        chk("sig01_idx", 32'(b2.pattern_idx), 32'h1);

        // Start and abort together from DONE
        b2.start = 1;
        b2.abort = 1;
        tick();
        b2.start = 0;
        b2.abort = 0;
        chk("col_done", 32'(b2.done), 32'h0);
        chk("col_busy", 32'(b2.busy), 32'h0);
        chk("col_sig", 32'(b2.signature), 32'h0003);

        // All-zero response compacts to zero
        b2.resp_i = 2'b00;
        b2.start = 1;
        tick();
        b2.start = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (b2.done) break;
        end
        chk("sig00_edges", 32'(n), 32'd12);
        chk("sig00", 32'(b2.signature), 32'h0000);

        // Seed 0 sanitised, sequence wraps after 31
        b3.start = 1;
        tick();
        b3.start = 0;
        tick();
        chk("s0_stim0", 32'(b3.stim_o), 32'h01);
        repeat (4) tick();
        chk("s0_stim1", 32'(b3.stim_o), 32'h02);
        repeat (120) tick();
        chk("wrap_idx", 32'(b3.pattern_idx), 32'd31);
        chk("wrap_stim", 32'(b3.stim_o), 32'h01);
        repeat (3) tick();
        chk("wrap_done", 32'(b3.done), 32'h1);

        // Asynchronous reset mid-SETTLE
        b0.start = 1;
        tick();
        b0.start = 0;
        repeat (8) tick();
        chk("pre_rst_busy", 32'(b0.busy), 32'h1);
        chk("pre_rst_sig", 32'(b0.signature), 32'h0001);
        chk("pre_rst_stim", 32'(b0.stim_o), 32'h1E);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stim", 32'(b0.stim_o), 32'h0);
        chk("arst_busy", 32'(b0.busy), 32'h0);
        chk("arst_done", 32'(b0.done), 32'h0);
        chk("arst_sig", 32'(b0.signature), 32'h0);
        chk("arst_idx", 32'(b0.pattern_idx), 32'h0);
        chk("arst_done3", 32'(b3.done), 32'h0);
        #4;
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
